// File: rtl/rng_share_arb.sv
// rng_share_arb: round-robin arbiter that shares one 4-bit maximal-length LFSR
// (x^4+x^3+1, period 15) among NREQ requesters over a req/ack handshake.
// Each grant steps the LFSR once and returns the new nibble. The block also
// handles seeding, active-low grant enable and the wrap carry pulse.
//
// Optional build macro: RNG_FREE_RUN_EN
//   defined   - LFSR also steps every idle cycle with enable_n low and no grant
//               or seed load (timing-dependent entropy); carry only on grants.
//   undefined - LFSR steps only on grants (deterministic sequence per grant).
module rng_share_arb #(
    parameter int unsigned NREQ     = 4,
    parameter logic [3:0]  SEED_RST = 4'b0001
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_seed_load,
    input  logic [3:0]      i_seed_in,
    output logic [NREQ-1:0] o_ack,
    output logic [3:0]      o_rnd_out,
    output logic            o_carry,
    output logic            o_busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRecover
    } state_e;

    // Registered state
    state_e          r_state;
    logic [3:0]      r_lfsr;
    logic [3:0]      r_seed;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_g;
    logic [NREQ-1:0] r_ack;
    logic [3:0]      r_rnd;
    logic            r_carry;

    // Next-state values
    state_e          w_state_d;
    logic [3:0]      w_lfsr_d;
    logic [3:0]      w_seed_d;
    logic [PW-1:0]   w_ptr_d;
    logic [PW-1:0]   w_g_d;
    logic [NREQ-1:0] w_ack_d;
    logic [3:0]      w_rnd_d;
    logic            w_carry_d;

    // Helpers
    logic [3:0]      w_lfsr_step;
    logic [3:0]      w_seed_fix;
    logic [PW-1:0]   w_pick;
    logic            w_pick_vld;
    logic [PW-1:0]   w_pick_idx;
    logic [PW-1:0]   w_ptr_inc;

    // One LFSR step; the all-zero state is unreachable because seeds are forced nonzero.
    assign w_lfsr_step = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

    // A zero seed would lock the LFSR, so it is replaced by 0001.
    assign w_seed_fix = (i_seed_in == 4'b0000) ? 4'b0001 : i_seed_in;

    // Pointer advances past the granted requester, wrapping at NREQ.
    assign w_ptr_inc = (r_g == PW'(NREQ - 1)) ? '0 : r_g + PW'(1);

    // Cyclic priority search: first requester at or after r_ptr.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_pick_idx = PW'((32'(r_ptr) + i) % NREQ);
            if (!w_pick_vld && i_req[w_pick_idx]) begin
                w_pick     = w_pick_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        w_state_d = r_state;
        w_lfsr_d  = r_lfsr;
        w_seed_d  = r_seed;
        w_ptr_d   = r_ptr;
        w_g_d     = r_g;
        w_ack_d   = r_ack;
        w_rnd_d   = r_rnd;
        w_carry_d = r_carry;

        unique case (r_state)
            StIdle: begin
                if (i_seed_load) begin
                    // Seed load wins over a same-cycle grant.
                    w_lfsr_d = w_seed_fix;
                    w_seed_d = w_seed_fix;
                end else if (!i_enable_n && w_pick_vld) begin
                    w_g_d     = w_pick;
                    w_state_d = StGrant;
                end
`ifdef RNG_FREE_RUN_EN
                else if (!i_enable_n) begin
                    w_lfsr_d = w_lfsr_step;
                end
`endif
            end

            StGrant: begin
                w_ack_d      = '0;
                w_ack_d[r_g] = 1'b1;
                w_rnd_d      = w_lfsr_step;
                w_lfsr_d     = w_lfsr_step;
                w_carry_d    = (w_lfsr_step == r_seed);
                w_ptr_d      = w_ptr_inc;
                w_state_d    = StRecover;
            end

            StRecover: begin
                // req is ignored here so the granted requester can drop it.
                w_ack_d   = '0;
                w_carry_d = 1'b0;
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any grant in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_lfsr  <= SEED_RST;
            r_seed  <= SEED_RST;
            r_ptr   <= '0;
            r_g     <= '0;
            r_ack   <= '0;
            r_rnd   <= 4'b0000;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_lfsr  <= w_lfsr_d;
            r_seed  <= w_seed_d;
            r_ptr   <= w_ptr_d;
            r_g     <= w_g_d;
            r_ack   <= w_ack_d;
            r_rnd   <= w_rnd_d;
            r_carry <= w_carry_d;
        end
    end

    assign o_ack     = r_ack;
    assign o_rnd_out = r_rnd;
    assign o_carry   = r_carry;
    assign o_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_rng_share_arb.sv
// Self-checking bench for rng_share_arb (default build, free-run disabled).
// Expected grants are queued when stimulus is driven and compared by a monitor
// whenever the DUT pulses ack.
module tb_rng_share_arb;

    logic       clk;
    logic       i_rst;
    logic       i_enable_n;
    logic [3:0] i_req;
    logic       i_seed_load;
    logic [3:0] i_seed_in;
    logic [3:0] o_ack;
    logic [3:0] o_rnd_out;
    logic       o_carry;
    logic       o_busy;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] rnd;
        logic       carry;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rng_share_arb #(
        .NREQ    (4),
        .SEED_RST(4'b0001)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_enable_n (i_enable_n),
        .i_req      (i_req),
        .i_seed_load(i_seed_load),
        .i_seed_in  (i_seed_in),
        .o_ack      (o_ack),
        .o_rnd_out  (o_rnd_out),
        .o_carry    (o_carry),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Scoreboard monitor: every ack pulse must match the oldest queued grant.
    always @(negedge clk) begin
        if (o_ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexp_ack", {28'b0, o_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_ack", {28'b0, o_ack}, {28'b0, e.ack});
                check_eq("sb_rnd", {28'b0, o_rnd_out}, {28'b0, e.rnd});
                check_eq("sb_carry", {31'b0, o_carry}, {31'b0, e.carry});
            end
        end
    end

    // Called at a negedge: drive req, then follow the grant through all three cycles.
    task automatic do_grant(input logic [3:0] req_v, input logic [3:0] ack_v,
                            input logic [3:0] rnd_v, input logic car_v);
        exp_t e;
        e.ack   = ack_v;
        e.rnd   = rnd_v;
        e.carry = car_v;
        sb.push_back(e);
        i_req = req_v;
        @(negedge clk);
        check_eq("busy_grant", {31'b0, o_busy}, 32'd1);
        check_eq("ack_early", {28'b0, o_ack}, 32'd0);
        @(negedge clk);
        check_eq("ack_lat", {28'b0, o_ack}, {28'b0, ack_v});
        check_eq("busy_ack", {31'b0, o_busy}, 32'd1);
        i_req = 4'b0000;
        @(negedge clk);
        check_eq("ack_clr", {28'b0, o_ack}, 32'd0);
        check_eq("carry_clr", {31'b0, o_carry}, 32'd0);
        check_eq("busy_clr", {31'b0, o_busy}, 32'd0);
        check_eq("rnd_hold", {28'b0, o_rnd_out}, {28'b0, rnd_v});
    endtask

    task automatic load_seed(input logic [3:0] v);
        i_seed_load = 1'b1;
        i_seed_in   = v;
        @(negedge clk);
        check_eq("load_idle", {31'b0, o_busy}, 32'd0);
        i_seed_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, {28'b0, o_ack}, 32'd0);
        check_eq({tag, "_rnd"}, {28'b0, o_rnd_out}, 32'd0);
        check_eq({tag, "_carry"}, {31'b0, o_carry}, 32'd0);
        check_eq({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] m;
        exp_t       e;
        int         waited;

        i_rst       = 1'b1;
        i_enable_n  = 1'b0;
        i_req       = 4'b0000;
        i_seed_load = 1'b0;
        i_seed_in   = 4'b0000;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        i_rst = 1'b0;
        @(negedge clk);

        // Seed 1001 then three grants to requester 0.
        load_seed(4'b1001);
        do_grant(4'b0001, 4'b0001, 4'b0011, 1'b0);
        do_grant(4'b0001, 4'b0001, 4'b0110, 1'b0);
        do_grant(4'b0001, 4'b0001, 4'b1101, 1'b0);

        // Wrap: the 15th grant returns the seed with carry.
        load_seed(4'b1001);
        m = 4'b1001;
        for (int k = 0; k < 15; k++) begin
            m = lfsr_next(m);
            do_grant(4'b0001, 4'b0001, m, (m == 4'b1001));
        end

        // Zero seed becomes 0001.
        load_seed(4'b0000);
        do_grant(4'b0001, 4'b0001, 4'b0010, 1'b0);
        // Load and req together: load wins, grant follows a cycle later.
        i_req       = 4'b0001;
        i_seed_load = 1'b1;
        i_seed_in   = 4'b0000;
        @(negedge clk);
        check_eq("load_wins_busy", {31'b0, o_busy}, 32'd0);
        i_seed_load = 1'b0;
        do_grant(4'b0001, 4'b0001, 4'b0010, 1'b0);

        // Enable gating.
        i_enable_n = 1'b1;
        i_req      = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("gated_ack", {28'b0, o_ack}, 32'd0);
            check_eq("gated_busy", {31'b0, o_busy}, 32'd0);
        end
        i_enable_n = 1'b0;
        do_grant(4'b0100, 4'b0100, 4'b0100, 1'b0);

        // Reset while in GRANT: no ack, reset values, LFSR back to 0001.
        i_req = 4'b0001;
        @(negedge clk);
        check_eq("mid_busy", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b1;
        i_req = 4'b0000;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        i_rst = 1'b0;
        do_grant(4'b0001, 4'b0001, 4'b0010, 1'b0);

        // Round robin with all requests held from reset.
        i_rst = 1'b1;
        i_req = 4'b1111;
        @(negedge clk);
        m = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            m = lfsr_next(m);
            e.ack   = 4'b0001 << (k % 4);
            e.rnd   = m;
            e.carry = 1'b0;
            sb.push_back(e);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (o_ack == 4'b0000 && waited < 8);
            check_eq("rr_found", {31'b0, (o_ack != 4'b0000)}, 32'd1);
            check_eq((k == 0) ? "rr_lat" : "rr_gap", waited, (k == 0) ? 32'd2 : 32'd3);
            if (k == 4) i_req = 4'b0000;
        end
        repeat (4) @(negedge clk);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
